master_arb_port: RTL

Master-side endpoint of the shared-bus arbitration and split-transaction handshake. One instance sits beside each bus master. It raises that master's request line, waits for grant while the bus is free, and holds the bus by pulling the shared utilisation line. It releases the bus on completion or when a slave splits the transaction, and re-acquires the bus when the bus controller re-grants after the slave finishes.

---
 rtl/master_arb_port.sv | 116 +++++++++++
 1 files changed

// File: rtl/master_arb_port.sv
// Master-side bus arbitration port: request/grant/hold handshake with split release and re-acquire.
// Optional REQ timeout is compiled in when MASTER_TIMEOUT_EN is defined.
module master_arb_port #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start,
  input  logic       tx_last,
  input  logic       tx_split,
  input  logic       m_grant,
  input  logic       bus_util,
  output logic       m_req,
  output logic       m_hold,
  output logic       bus_owned,
  output logic       tx_done,
  output logic       tx_resumed,
  output logic       tx_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ        = 3'd1,
    TAKE       = 3'd2,
    OWN        = 3'd3,
    RELEASE    = 3'd4,
    SPLIT_DROP = 3'd5,
    SPLIT_WAIT = 3'd6,
    RETAKE     = 3'd7
  } state_e;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic   grant_ok;
  logic   expired;
  logic   m_req_q, m_hold_q, bus_owned_q, tx_done_q, tx_resumed_q, tx_timeout_q;

  // A grant is usable only while no other master is holding the bus.
  assign grant_ok = m_grant & bus_util;

`ifdef MASTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counter rests at zero outside REQ, so it is already cleared on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == REQ && !grant_ok) cnt_d = cnt_q + 16'd1;
  end

  assign expired = (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign expired        = 1'b0;
  assign unused_timeout = ^LIMIT;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (tx_start)     state_d = REQ;
      REQ: begin
        if (grant_ok)               state_d = TAKE;
        else if (expired)           state_d = IDLE;
      end
      TAKE:                         state_d = OWN;
      OWN: begin
        if (tx_last)                state_d = RELEASE;
        else if (tx_split)          state_d = SPLIT_DROP;
      end
      RELEASE:    if (!m_grant)     state_d = IDLE;
      SPLIT_DROP: if (!m_grant)     state_d = SPLIT_WAIT;
      SPLIT_WAIT: if (grant_ok)     state_d = RETAKE;
      RETAKE:                       state_d = OWN;
      default:                      state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
    if (!rstn) begin
      state_q      <= IDLE;
      m_req_q      <= 1'b0;
      m_hold_q     <= 1'b0;
      bus_owned_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_resumed_q <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= state_d inside {REQ, TAKE, OWN, SPLIT_DROP, SPLIT_WAIT, RETAKE};
      m_hold_q     <= state_d inside {TAKE, OWN, RETAKE};
      bus_owned_q  <= (state_d == OWN);
      tx_done_q    <= (state_d == RELEASE) && (state_q != RELEASE);
      tx_resumed_q <= (state_d == OWN) && (state_q == RETAKE);
      tx_timeout_q <= (state_q == REQ) && (state_d == IDLE);
    end
  end

  assign m_req      = m_req_q;
  assign m_hold     = m_hold_q;
  assign bus_owned  = bus_owned_q;
  assign tx_done    = tx_done_q;
  assign tx_resumed = tx_resumed_q;
  assign tx_timeout = tx_timeout_q;
  assign state      = state_q;

endmodule
